// File: rtl/btb_lru_tracker_if.sv
// Bus between the BTB controller and its true-LRU replacement tracker.
// Lock signals exist only when BTB_LRU_LOCK_EN is defined.
interface btb_lru_tracker_if #(
  parameter int LINE_W = 3
);
  logic              en;
  logic              hit;
  logic [LINE_W-1:0] hit_line;
  logic              inval;
  logic [LINE_W-1:0] inval_line;
  logic [LINE_W-1:0] lru_line;
  logic              lru_valid;
  logic              full;
`ifdef BTB_LRU_LOCK_EN
  logic              lock;
  logic [LINE_W-1:0] lock_line;
  logic              lock_set;
  logic              no_victim;

  modport master (
    output en, hit, hit_line, inval, inval_line, lock, lock_line, lock_set,
    input  lru_line, lru_valid, full, no_victim
  );
  modport slave (
    input  en, hit, hit_line, inval, inval_line, lock, lock_line, lock_set,
    output lru_line, lru_valid, full, no_victim
  );
`else
  modport master (
    output en, hit, hit_line, inval, inval_line,
    input  lru_line, lru_valid, full
  );
  modport slave (
    input  en, hit, hit_line, inval, inval_line,
    output lru_line, lru_valid, full
  );
`endif
endinterface

// File: rtl/btb_lru_tracker.sv
// True-LRU replacement tracker for the BTB: one age rank and valid bit per line,
// combinational victim output. Optional per-line locking under BTB_LRU_LOCK_EN.
module btb_lru_tracker #(
  parameter int LINE_NUM = 8,
  parameter int LINE_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  btb_lru_tracker_if.slave  bus
);

  logic [LINE_W-1:0]   age_reg  [LINE_NUM];
  logic [LINE_W-1:0]   age_next [LINE_NUM];
  logic [LINE_NUM-1:0] valid_reg;
  logic [LINE_NUM-1:0] valid_next;
  logic [LINE_NUM-1:0] cand;
  logic [LINE_NUM-1:0] hit_sel;
  logic [LINE_NUM-1:0] inval_sel;
  logic [LINE_NUM-1:0] victim_sel;
  logic [LINE_NUM-1:0] touch_sel;
  logic [LINE_W-1:0]   victim;
  logic [LINE_W-1:0]   victim_age;
  logic [LINE_W-1:0]   hit_age;
  logic [LINE_W-1:0]   inval_age;
  logic [LINE_W-1:0]   touch_age;
  logic [LINE_W-1:0]   best_age;
  logic                victim_ok;
  logic                hit_ok;
  logic                inval_ok;
  logic                touch_do;
  logic                inval_do;

`ifdef BTB_LRU_LOCK_EN
  logic [LINE_NUM-1:0] lock_reg;
  logic [LINE_NUM-1:0] lock_next;
  logic [LINE_NUM-1:0] lock_sel;

  assign cand          = ~lock_reg;
  assign bus.no_victim = &(valid_reg & lock_reg);
`else
  assign cand = '1;
`endif

  // Out-of-range indices match no line, so their select vectors stay zero.
  for (genvar gi = 0; gi < LINE_NUM; gi++) begin : g_sel
    assign hit_sel[gi]    = (bus.hit_line   == LINE_W'(gi));
    assign inval_sel[gi]  = (bus.inval_line == LINE_W'(gi));
    assign victim_sel[gi] = (victim         == LINE_W'(gi));
`ifdef BTB_LRU_LOCK_EN
    assign lock_sel[gi]   = (bus.lock_line  == LINE_W'(gi));
`endif
  end

  assign hit_ok = |hit_sel;
  assign inval_ok = |inval_sel;

  // Lowest-index invalid candidate first, otherwise the oldest candidate.
  always_comb begin
    victim    = '0;
    victim_ok = 1'b0;
    best_age  = '0;
    for (int i = 0; i < LINE_NUM; i++) begin
      if (!victim_ok && !valid_reg[i] && cand[i]) begin
        victim    = LINE_W'(i);
        victim_ok = 1'b1;
      end
    end
    if (!victim_ok) begin
      for (int i = 0; i < LINE_NUM; i++) begin
        if (cand[i] && (!victim_ok || age_reg[i] > best_age)) begin
          victim    = LINE_W'(i);
          best_age  = age_reg[i];
          victim_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    hit_age    = '0;
    inval_age  = '0;
    victim_age = '0;
    for (int i = 0; i < LINE_NUM; i++) begin
      if (hit_sel[i])    hit_age    = hit_age    | age_reg[i];
      if (inval_sel[i])  inval_age  = inval_age  | age_reg[i];
      if (victim_sel[i]) victim_age = victim_age | age_reg[i];
    end
  end

  // Invalidate wins over a same-cycle access; the controller re-issues it.
  assign inval_do  = bus.inval && inval_ok;
  assign touch_do  = bus.en && !bus.inval && (bus.hit ? hit_ok : victim_ok);
  assign touch_sel = bus.hit ? hit_sel : victim_sel;
  assign touch_age = bus.hit ? hit_age : victim_age;

  for (genvar gi = 0; gi < LINE_NUM; gi++) begin : g_next
    assign age_next[gi] =
        inval_do ? (inval_sel[gi]             ? LINE_W'(LINE_NUM-1) :
                    (age_reg[gi] > inval_age) ? age_reg[gi] - 1'b1  : age_reg[gi]) :
        touch_do ? (touch_sel[gi]             ? '0                  :
                    (age_reg[gi] < touch_age) ? age_reg[gi] + 1'b1  : age_reg[gi]) :
                   age_reg[gi];
    assign valid_next[gi] =
        (inval_do && inval_sel[gi])             ? 1'b0 :
        (touch_do && touch_sel[gi] && !bus.hit) ? 1'b1 : valid_reg[gi];
`ifdef BTB_LRU_LOCK_EN
    assign lock_next[gi] =
        (inval_do && inval_sel[gi]) ? 1'b0         :
        (bus.lock && lock_sel[gi])  ? bus.lock_set : lock_reg[gi];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_NUM; i++) begin
        age_reg[i] <= LINE_W'(LINE_NUM - 1 - i);
      end
      valid_reg <= '0;
`ifdef BTB_LRU_LOCK_EN
      lock_reg  <= '0;
`endif
    end else begin
      for (int i = 0; i < LINE_NUM; i++) begin
        age_reg[i] <= age_next[i];
      end
      valid_reg <= valid_next;
`ifdef BTB_LRU_LOCK_EN
      lock_reg  <= lock_next;
`endif
    end
  end

  assign bus.lru_line  = victim;
  assign bus.lru_valid = valid_reg[victim];
  assign bus.full      = &valid_reg;

endmodule

// File: tb/tb_btb_lru_tracker.sv
// Self-checking bench for btb_lru_tracker (LINE_NUM=8) against a recency-list model.
module tb_btb_lru_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  btb_lru_tracker_if #(.LINE_W(3)) bus ();

  btb_lru_tracker #(.LINE_NUM(8), .LINE_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: order[0] is the most recently used line, order[$] the least.
  int order[$];
  bit mvalid[8];

  function automatic void m_reset();
    order = {};
    for (int i = 7; i >= 0; i--) order.push_back(i);
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
  endfunction

  function automatic void m_remove(input int k);
    for (int i = 0; i < order.size(); i++) begin
      if (order[i] == k) begin
        order.delete(i);
        break;
      end
    end
  endfunction

  function automatic int m_victim();
    for (int i = 0; i < 8; i++) if (!mvalid[i]) return i;
    return order[$];
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < 8; i++) if (!mvalid[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_apply(input bit e, input bit h, input int hl, input bit iv, input int il);
    int v;
    if (iv) begin
      m_remove(il);
      order.push_back(il);
      mvalid[il] = 1'b0;
    end else if (e) begin
      v = h ? hl : m_victim();
      m_remove(v);
      order.push_front(v);
      if (!h) mvalid[v] = 1'b1;
    end
  endfunction

  // One cycle of stimulus; returns 1 ns after the sampling edge.
  task automatic drive(input bit e, input bit h, input int hl, input bit iv, input int il);
    bus.en         = e;
    bus.hit        = h;
    bus.hit_line   = 3'(hl);
    bus.inval      = iv;
    bus.inval_line = 3'(il);
    m_apply(e, h, hl, iv, il);
    @(posedge clk);
    #1;
    bus.en    = 1'b0;
    bus.hit   = 1'b0;
    bus.inval = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    checks++; if (bus.lru_line !== 3'd0) $display("FAIL reset_lru_line: got %0d want 0", bus.lru_line); else passes++;
    checks++; if (bus.lru_valid !== 1'b0) $display("FAIL reset_lru_valid: got %0b want 0", bus.lru_valid); else passes++;
    checks++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %0b want 0", bus.full); else passes++;
  endtask

  task automatic test_fill_sequence();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.lru_line !== 3'(i)) $display("FAIL fill_order[%0d]: got %0d want %0d", i, bus.lru_line, i); else passes++;
      drive(1, 0, 0, 0, 0);
    end
    checks++; if (bus.full !== 1'b1) $display("FAIL fill_full: got %0b want 1", bus.full); else passes++;
    checks++; if (bus.lru_valid !== 1'b1) $display("FAIL fill_lru_valid: got %0b want 1", bus.lru_valid); else passes++;
    checks++; if (bus.lru_line !== 3'd0) $display("FAIL fill_lru_line: got %0d want 0", bus.lru_line); else passes++;
  endtask

  task automatic test_hit_promote();
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 3, 0, 0);
    checks++; if (bus.lru_line !== 3'd1) $display("FAIL hit_lru_line: got %0d want 1", bus.lru_line); else passes++;
    drive(1, 1, 0, 0, 0);
    checks++; if (bus.lru_line !== 3'd1) $display("FAIL hit_mru_repeat: got %0d want 1", bus.lru_line); else passes++;
    drive(1, 0, 0, 0, 0);
    checks++; if (bus.lru_line !== 3'd2) $display("FAIL evict_line1_next: got %0d want 2", bus.lru_line); else passes++;
  endtask

  task automatic test_invalidate();
    drive(0, 0, 0, 1, 5);
    checks++; if (bus.lru_line !== 3'd5) $display("FAIL inval_lru_line: got %0d want 5", bus.lru_line); else passes++;
    checks++; if (bus.lru_valid !== 1'b0) $display("FAIL inval_lru_valid: got %0b want 0", bus.lru_valid); else passes++;
    checks++; if (bus.full !== 1'b0) $display("FAIL inval_full: got %0b want 0", bus.full); else passes++;
    drive(1, 0, 0, 0, 0);
    checks++; if (bus.full !== 1'b1) $display("FAIL refill5_full: got %0b want 1", bus.full); else passes++;
    checks++; if (bus.lru_line !== 3'(m_victim())) $display("FAIL refill5_lru_line: got %0d want %0d", bus.lru_line, m_victim()); else passes++;
  endtask

  task automatic test_inval_priority();
    drive(1, 1, 2, 1, 2);
    checks++; if (bus.lru_line !== 3'd2) $display("FAIL prio_lru_line: got %0d want 2", bus.lru_line); else passes++;
    checks++; if (bus.lru_valid !== 1'b0) $display("FAIL prio_lru_valid: got %0b want 0", bus.lru_valid); else passes++;
    drive(1, 0, 0, 0, 0);
    checks++; if (bus.lru_line !== 3'(m_victim())) $display("FAIL prio_after_fill: got %0d want %0d", bus.lru_line, m_victim()); else passes++;
  endtask

  task automatic test_back_to_back();
    int exp_line[3] = '{1, 4, 6};
    drive(0, 0, 0, 1, 6);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 4);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.lru_line !== 3'(exp_line[i])) $display("FAIL b2b_fill[%0d]: got %0d want %0d", i, bus.lru_line, exp_line[i]); else passes++;
      drive(1, 0, 0, 0, 0);
    end
    checks++; if (bus.full !== 1'b1) $display("FAIL b2b_full: got %0b want 1", bus.full); else passes++;
    checks++; if (bus.lru_line !== 3'(m_victim())) $display("FAIL b2b_lru_line: got %0d want %0d", bus.lru_line, m_victim()); else passes++;
  endtask

  task automatic test_random();
    int v;
    for (int n = 0; n < 300; n++) begin
      bit iv = ($urandom_range(0, 99) < 15);
      bit e  = ($urandom_range(0, 99) < 75);
      bit h  = $urandom_range(0, 1);
      drive(e, h, $urandom_range(0, 7), iv, $urandom_range(0, 7));
      v = m_victim();
      checks++; if (bus.lru_line !== 3'(v)) $display("FAIL rand_lru_line[%0d]: got %0d want %0d", n, bus.lru_line, v); else passes++;
      checks++; if (bus.lru_valid !== mvalid[v]) $display("FAIL rand_lru_valid[%0d]: got %0b want %0b", n, bus.lru_valid, mvalid[v]); else passes++;
      checks++; if (bus.full !== m_full()) $display("FAIL rand_full[%0d]: got %0b want %0b", n, bus.full, m_full()); else passes++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.lru_line !== 3'd0) $display("FAIL areset_lru_line: got %0d want 0", bus.lru_line); else passes++;
    checks++; if (bus.lru_valid !== 1'b0) $display("FAIL areset_lru_valid: got %0b want 0", bus.lru_valid); else passes++;
    checks++; if (bus.full !== 1'b0) $display("FAIL areset_full: got %0b want 0", bus.full); else passes++;
    #2 rst = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0);
    checks++; if (bus.lru_line !== 3'd1) $display("FAIL areset_first_fill: got %0d want 1", bus.lru_line); else passes++;
  endtask

`ifdef BTB_LRU_LOCK_EN
  task automatic lock_cycle(input int line, input bit set);
    bus.lock      = 1'b1;
    bus.lock_line = 3'(line);
    bus.lock_set  = set;
    @(posedge clk);
    #1;
    bus.lock = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 0);
    lock_cycle(0, 1);
    lock_cycle(1, 1);
    checks++; if (bus.lru_line !== 3'd2) $display("FAIL lock01_lru_line: got %0d want 2", bus.lru_line); else passes++;
    for (int i = 2; i < 8; i++) lock_cycle(i, 1);
    checks++; if (bus.no_victim !== 1'b1) $display("FAIL lock_all_no_victim: got %0b want 1", bus.no_victim); else passes++;
    checks++; if (bus.lru_line !== 3'd0) $display("FAIL lock_all_lru_line: got %0d want 0", bus.lru_line); else passes++;
    bus.en = 1'b1; bus.hit = 1'b0;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    lock_cycle(5, 0);
    checks++; if (bus.lru_line !== 3'd5) $display("FAIL lock_only5_lru_line: got %0d want 5", bus.lru_line); else passes++;
    for (int i = 0; i < 8; i++) lock_cycle(i, 0);
    checks++; if (bus.lru_line !== 3'd0) $display("FAIL lock_dropped_fill: got %0d want 0", bus.lru_line); else passes++;
    do_reset();
  endtask
`endif

  initial begin
    bus.en = 1'b0; bus.hit = 1'b0; bus.hit_line = '0;
    bus.inval = 1'b0; bus.inval_line = '0;
`ifdef BTB_LRU_LOCK_EN
    bus.lock = 1'b0; bus.lock_line = '0; bus.lock_set = 1'b0;
`endif
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_fill_sequence();
    test_hit_promote();
    test_invalidate();
    test_inval_priority();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef BTB_LRU_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/btb_lru_tracker.md
# btb_lru_tracker

Parametrised true-LRU replacement tracker for the branch target buffer, replacing the fixed 8-line LRU counter. Keeps one age rank per line plus a valid bit, promotes lines on hit or fill, invalidates lines on request, and presents the victim line combinationally to the BTB fill path. Invalid lines are always victimised before valid ones.

## Interface
- `LINE_NUM`, default 8: number of BTB lines tracked; must be at least 2.
- `LINE_W`, default 3: index and age width; must equal `$clog2(LINE_NUM)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `en`  in  1  access strobe, one BTB lookup per cycle.
- `hit`  in  1  qualifies `en`: 1 = hit on `hit_line`; 0 = miss, fill `lru_line`.
- `hit_line`  in  `LINE_W`  line that hit.
- `inval`  in  1  invalidate strobe.
- `inval_line`  in  `LINE_W`  line to invalidate.
- `lru_line`  out  `LINE_W`  current victim index.
- `lru_valid`  out  1  victim holds valid data, so a fill evicts an entry.
- `full`  out  1  all lines valid.
- Additional ports exist only under `BTB_LRU_LOCK_EN`; see Configuration.

## Operation
- State per line i: `age[i]` (`LINE_W` bits) and `valid[i]`.
- Ages always form a permutation of 0..LINE_NUM-1.
  - Age 0 = MRU.
  - Age LINE_NUM-1 = LRU.
- Touch(k), where `a` = `age[k]`:
  - Every line with age < a increments.
  - `age[k]` becomes 0.
  - All other ages are unchanged.
- Hit (`en && hit`): touch(`hit_line`). Valid bits unchanged; a hit on an invalid line is still touched.
- Fill (`en && !hit`): touch(`lru_line`) and set `valid[lru_line]`.
- Invalidate (`inval`), where `a` = `age[inval_line]`:
  - Clear `valid[inval_line]`.
  - Every line with age > a decrements.
  - `age[inval_line]` becomes LINE_NUM-1.
- Victim selection:
  - If any line is invalid, victim = lowest-index invalid line.
  - Otherwise victim = the line with age LINE_NUM-1.
- `lru_valid` = `valid[lru_line]`.
- `full` = AND of all valid bits.
- Index >= LINE_NUM (non-power-of-two LINE_NUM): that hit, fill or invalidate is ignored; no state change.
- Simultaneous `inval` and `en`: invalidate takes priority and the access is dropped for that cycle. The BTB controller re-issues a dropped access.
- Repeated hit on the MRU line (age 0): no age changes.

## Timing
- Reset values:
  - `age[i]` = LINE_NUM-1-i, so line 0 is LRU.
  - All valid bits = 0.
  - `lru_line` = 0, `lru_valid` = 0, `full` = 0.
- Reset asserted mid-operation clears state immediately; outputs take reset values within the same cycle.
- Victim lookup has zero latency: outputs are combinational from registered state.
- Updates have one-cycle latency: an access or invalidate at edge N is visible on the outputs after edge N.
- A fill at edge N uses the `lru_line` value present before edge N.
- Back-to-back fills on consecutive cycles target distinct lines.

## Configuration
- `BTB_LRU_LOCK_EN` defined: adds per-line lock state and these ports:
  - `lock`  in  1  lock update strobe.
  - `lock_line`  in  `LINE_W`  target line.
  - `lock_set`  in  1  1 = lock, 0 = unlock.
  - `no_victim`  out  1  every line is valid and locked.
- Lock behaviour:
  - Locked lines are excluded from victim selection.
  - With all lines valid, victim = the unlocked line with the highest age.
  - When `no_victim` = 1, `lru_line` holds 0 and fills are dropped (no state change).
  - Locks reset to 0.
  - A lock update in the same cycle as an access takes effect for the next cycle's selection.
  - Invalidate also clears the line's lock.
  - Hits and ages are unaffected by locks.
- `BTB_LRU_LOCK_EN` undefined:
  - No lock state and no lock ports.
  - Victim selection uses valid bits and ages only.

## Test plan
- Reset, LINE_NUM=8, no access -> `lru_line`=0, `lru_valid`=0, `full`=0.
- 8 consecutive fills -> lines 0..7 filled in order; then `full`=1, `lru_valid`=1, `lru_line`=0.
- From the full state, hit line 0 then hit line 3 -> `lru_line`=1; a fill now evicts line 1.
- From the full state, invalidate line 5 -> `lru_line`=5, `lru_valid`=0, `full`=0; the next fill refills line 5.
- `inval` on line 2 together with `en`/`hit` on line 2 -> line 2 invalid at age 7; the hit is dropped; `lru_line`=2.
- Lock build, full state with lines 0 and 1 locked -> `lru_line`=2; lock all 8 -> `no_victim`=1, and a fill leaves ages unchanged.
